// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side port of the load/store unit.
// slave is the LSU's own view; master is the surrounding core plus memory.
interface load_store_unit_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        output busy_o, done_o, err_o, rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        input  busy_o, done_o, err_o, rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load or store per request over a req/ack port,
// with byte-lane steering, load extension, alignment/size checks and timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        illegal, misaligned;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    // Request decode, evaluated combinationally on the IDLE-cycle inputs.
    always_comb begin
        if (bus.we_i)
            illegal = (bus.funct3_i > 3'b010);
        else
            illegal = (bus.funct3_i == 3'b011) || (bus.funct3_i[2:1] == 2'b11);
        misaligned = ((bus.funct3_i[1:0] == 2'b01) && bus.addr_i[0]) ||
                     ((bus.funct3_i[1:0] == 2'b10) && (bus.addr_i[1:0] != 2'b00));
        case (bus.funct3_i[1:0])
            2'b00: begin
                be_req    = 4'b0001 << bus.addr_i[1:0];
                wdata_req = {4{bus.wdata_i[7:0]}};
            end
            2'b01: begin
                be_req    = bus.addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_req = {2{bus.wdata_i[15:0]}};
            end
            default: begin
                be_req    = 4'b1111;
                wdata_req = bus.wdata_i;
            end
        endcase
    end

    // Load lane select and extension from the latched size/offset.
    always_comb begin
        ld_byte = 8'(bus.mem_rdata_i >> {off_q, 3'b000});
        ld_half = off_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h0, ld_byte};
            3'b101:  ld_fmt = {16'h0, ld_half};
            default: ld_fmt = bus.mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_i) begin
                    if (illegal || misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                        we_d    = bus.we_i;
                        f3_d    = bus.funct3_i;
                        off_d   = bus.addr_i[1:0];
                        addr_d  = {bus.addr_i[31:2], 2'b00};
                        be_d    = be_req;
                        wdata_d = wdata_req;
                    end
                end
            end
            ACCESS: begin
                // Acknowledge takes priority over an expiring counter.
                if (bus.mem_ack_i) begin
                    if (!we_q)
                        rdata_d = ld_fmt;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == DONE);
    assign bus.err_o       = err_q && (state_q == DONE);
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_req_o   = (state_q == ACCESS);
    assign bus.mem_we_o    = we_q && (state_q == ACCESS);
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_be_o    = be_q;
    assign bus.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected completions are queued when a
// request is driven and compared when done_o appears.
module tb_load_store_unit;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if bus();
    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdata_model = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rword, input int waits);
        logic        bad_acc;
        logic [3:0]  ebe;
        logic [31:0] ewd, eload;
        logic [7:0]  b;
        logic [15:0] h;
        int          exp_cyc, cyc, busy_cyc;
        logic        done_seen;
        exp_t        e;

        b       = 8'(rword >> (8 * addr[1:0]));
        h       = addr[1] ? rword[31:16] : rword[15:0];
        bad_acc = 1'b0;
        ebe     = '0;
        ewd     = '0;
        eload   = '0;
        case (f3)
            3'b000: begin ebe = 4'b0001 << addr[1:0]; ewd = {4{wdata[7:0]}};
                          eload = {{24{b[7]}}, b}; end
            3'b001: begin ebe = addr[1] ? 4'b1100 : 4'b0011; ewd = {2{wdata[15:0]}};
                          eload = {{16{h[15]}}, h}; bad_acc = addr[0]; end
            3'b010: begin ebe = 4'b1111; ewd = wdata; eload = rword;
                          bad_acc = (addr[1:0] != 2'b00); end
            3'b100: begin ebe = 4'b0001 << addr[1:0]; eload = {24'h0, b}; bad_acc = we; end
            3'b101: begin ebe = addr[1] ? 4'b1100 : 4'b0011; eload = {16'h0, h};
                          bad_acc = we | addr[0]; end
            default: bad_acc = 1'b1;
        endcase

        if (bad_acc) begin
            exp_cyc = 0; e.err = 1'b1; rdata_model = '0;
        end else if (waits < 0 || waits >= int'(TO)) begin
            exp_cyc = int'(TO); e.err = 1'b1; rdata_model = '0;
        end else begin
            exp_cyc = waits + 1; e.err = 1'b0;
            if (!we) rdata_model = eload;
        end
        e.rdata = rdata_model;
        sb.push_back(e);

        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.funct3_i = f3;
        bus.addr_i = addr; bus.wdata_i = wdata;
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = '0;
        bus.addr_i = '0; bus.wdata_i = '0;

        cyc = 0; busy_cyc = 0; done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            busy_cyc += int'(bus.busy_o);
            if (bus.done_o) begin
                done_seen = 1'b1;
                check("req_low_in_done", 32'(bus.mem_req_o), 32'd0);
            end else begin
                if (bus.mem_req_o) begin
                    cyc++;
                    check("mem_addr", bus.mem_addr_o, {addr[31:2], 2'b00});
                    check("mem_be", 32'(bus.mem_be_o), 32'(ebe));
                    check("mem_we", 32'(bus.mem_we_o), 32'(we));
                    if (we) check("mem_wdata", bus.mem_wdata_o, ewd);
                    bus.mem_ack_i   = (cyc - 1 == waits);
                    bus.mem_rdata_i = (cyc - 1 == waits) ? rword : ~rword;
                end
                @(posedge clk); #1;
                bus.mem_ack_i = 1'b0;
            end
        end
        check("done_seen", 32'(done_seen), 32'd1);
        check("access_cycles", 32'(cyc), 32'(exp_cyc));
        check("busy_cycles", 32'(busy_cyc), 32'(exp_cyc + 1));
        e = sb.pop_front();
        check("err", 32'(bus.err_o), 32'(e.err));
        check("rdata", bus.rdata_o, e.rdata);
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done_o), 32'd0);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy_o), 32'd0);
        check({tag, "_done"},  32'(bus.done_o), 32'd0);
        check({tag, "_err"},   32'(bus.err_o), 32'd0);
        check({tag, "_rdata"}, bus.rdata_o, 32'd0);
        check({tag, "_req"},   32'(bus.mem_req_o), 32'd0);
        check({tag, "_we"},    32'(bus.mem_we_o), 32'd0);
        check({tag, "_addr"},  bus.mem_addr_o, 32'd0);
        check({tag, "_be"},    32'(bus.mem_be_o), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = '0;
        bus.addr_i = '0; bus.wdata_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); rst = 1'b0;

        run(1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0);   // LW
        run(1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0);   // LB
        run(1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 1);   // LBU
        run(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        3);   // SH
        run(1'b0, 3'b010, 32'h101, 32'h0,        32'h11111111, 0);   // misaligned LW
        run(1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2);   // LH upper
        run(1'b1, 3'b011, 32'h100, 32'h12345678, 32'h0,        0);   // illegal store
        run(1'b0, 3'b101, 32'h100, 32'h0,        32'h1234ABCD, 0);   // LHU lower
        run(1'b0, 3'b010, 32'h300, 32'h0,        32'h55555555, -1);  // timeout
        run(1'b0, 3'b010, 32'h304, 32'h0,        32'hCAFEF00D, 3);   // ack on last cycle
        run(1'b1, 3'b000, 32'h401, 32'h0000005A, 32'h0,        1);   // SB
        run(1'b0, 3'b110, 32'h000, 32'h0,        32'h0,        0);   // illegal load
        run(1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0,        0);   // misaligned SH

        // Reset in the second wait cycle of a load aborts it silently.
        run(1'b0, 3'b010, 32'h700, 32'h0, 32'h87654321, 0);
        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.funct3_i = 3'b010; bus.addr_i = 32'h600;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        check("abort_wait1_req", 32'(bus.mem_req_o), 32'd1);
        @(posedge clk); #1;
        check("abort_wait2_req", 32'(bus.mem_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst = 1'b0;
        rdata_model = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(bus.done_o), 32'd0);
        end

        run(1'b0, 3'b010, 32'h500, 32'h0, 32'hA5A5C3C3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
